// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues word-aligned fetches, tracks in-flight requests,
// buffers responses in a small FIFO and discards stale responses after a redirect.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [6:0]  op,
  output logic [2:0]  func3,
  output logic [6:0]  func7
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW:0]   LIMIT = (CW + 1)'(DEPTH);
  localparam logic [PW-1:0] LAST  = PW'(DEPTH - 1);

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_rsp_pc;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_drop_count;
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [31:0]   r_buf_data [DEPTH];
  logic [31:0]   r_buf_pc   [DEPTH];

  logic [CW:0]   w_inflight;
  logic [31:0]   w_target;
  logic          w_req_fire;
  logic          w_rsp_ok;
  logic          w_push;
  logic          w_pop;
  logic [PW-1:0] w_head_nxt;
  logic [PW-1:0] w_tail_nxt;

  assign w_inflight = {1'b0, r_outstanding} + {1'b0, r_count};
  assign w_target   = {redirect_target[31:2], 2'b00};

  // rst_n gates the request so nothing is offered to memory while held in reset.
  assign imem_req_valid = rst_n & ~redirect_valid & (w_inflight < LIMIT);
  assign imem_req_addr  = r_fetch_pc;

  assign w_req_fire = imem_req_valid & imem_req_ready;
  // A response with nothing outstanding is a protocol error and is ignored.
  assign w_rsp_ok   = imem_rsp_valid & (r_outstanding != '0);
  assign w_push     = w_rsp_ok & ~redirect_valid & (r_drop_count == '0);
  assign w_pop      = instr_valid & instr_ready;
  assign w_head_nxt = (r_head == LAST) ? '0 : r_head + 1'b1;
  assign w_tail_nxt = (r_tail == LAST) ? '0 : r_tail + 1'b1;

  assign instr_valid = (r_count != '0);
  assign instr       = r_buf_data[r_head];
  assign instr_pc    = r_buf_pc[r_head];
  assign op          = instr[6:0];
  assign func3       = instr[14:12];
  assign func7       = instr[31:25];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc    <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= '0;
      r_count       <= '0;
      r_drop_count  <= '0;
      r_head        <= '0;
      r_tail        <= '0;
    end else if (redirect_valid) begin
      r_fetch_pc    <= w_target;
      r_rsp_pc      <= w_target;
      r_count       <= '0;
      r_head        <= '0;
      r_tail        <= '0;
      r_outstanding <= r_outstanding - CW'(w_rsp_ok);
      r_drop_count  <= r_outstanding - CW'(w_rsp_ok);
    end else begin
      if (w_req_fire) r_fetch_pc <= r_fetch_pc + 32'd4;
      r_outstanding <= r_outstanding + CW'(w_req_fire) - CW'(w_rsp_ok);
      if (w_rsp_ok && (r_drop_count != '0)) r_drop_count <= r_drop_count - 1'b1;
      if (w_push) begin
        r_tail   <= w_tail_nxt;
        r_rsp_pc <= r_rsp_pc + 32'd4;
      end
      if (w_pop) r_head <= w_head_nxt;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_buf_data[r_tail] <= imem_rsp_data;
      r_buf_pc[r_tail]   <= r_rsp_pc;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: the memory side is driven by hand, cycle by cycle,
// and every observed output is compared against a hand-computed value.
module tb_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [6:0]  op;
  logic [2:0]  func3;
  logic [6:0]  func7;

  int total = 0;
  int bad   = 0;

  instr_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .op              (op),
    .func3           (func3),
    .func7           (func7)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory contents used as stimulus: word at address a.
  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hA5C3_F0E7;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_target = '0; instr_ready = 1'b0;
    #1;
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_req_addr", imem_req_addr, 32'h0);
    tick(); tick();

    // A: first cycle out of reset, request at RESET_PC
    rst_n = 1'b1; imem_req_ready = 1'b1; instr_ready = 1'b1; #1;
    chk("A_req_valid", 32'(imem_req_valid), 32'd1);
    chk("A_req_addr", imem_req_addr, 32'h0);
    tick();
    // B: response for 0, request 4
    imem_rsp_valid = 1'b1; imem_rsp_data = mem(32'h0); #1;
    chk("B_instr_valid", 32'(instr_valid), 32'd0);
    chk("B_req_addr", imem_req_addr, 32'h4);
    chk("B_req_valid", 32'(imem_req_valid), 32'd1);
    tick();
    // C: head is PC 0, two accepted in total so request blocked
    imem_rsp_data = mem(32'h4); #1;
    chk("C_instr_valid", 32'(instr_valid), 32'd1);
    chk("C_instr_pc", instr_pc, 32'h0);
    chk("C_instr", instr, mem(32'h0));
    chk("C_req_valid", 32'(imem_req_valid), 32'd0);
    tick();
    // D
    imem_rsp_valid = 1'b0; #1;
    chk("D_instr_pc", instr_pc, 32'h4);
    chk("D_instr", instr, mem(32'h4));
    chk("D_req_addr", imem_req_addr, 32'h8);
    chk("D_req_valid", 32'(imem_req_valid), 32'd1);
    tick();
    // E
    imem_rsp_valid = 1'b1; imem_rsp_data = mem(32'h8); #1;
    chk("E_instr_valid", 32'(instr_valid), 32'd0);
    chk("E_req_addr", imem_req_addr, 32'hC);
    tick();
    // F: decode stalls from here
    imem_rsp_valid = 1'b0; instr_ready = 1'b0; #1;
    chk("F_instr_pc", instr_pc, 32'h8);
    chk("F_instr", instr, 32'hA5C3_F0EF);
    chk("F_op", 32'(op), 32'h6F);
    chk("F_func3", 32'(func3), 32'h7);
    chk("F_func7", 32'(func7), 32'h52);
    chk("F_req_valid", 32'(imem_req_valid), 32'd0);
    tick();
    // G
    imem_rsp_valid = 1'b1; imem_rsp_data = mem(32'hC); #1;
    chk("G_req_valid", 32'(imem_req_valid), 32'd0);
    chk("G_instr_pc", instr_pc, 32'h8);
    tick();
    // H: buffer full
    imem_rsp_valid = 1'b0; #1;
    chk("H_req_valid", 32'(imem_req_valid), 32'd0);
    chk("H_instr_pc", instr_pc, 32'h8);
    tick();
    // I
    #1;
    chk("I_req_valid", 32'(imem_req_valid), 32'd0);
    chk("I_instr_valid", 32'(instr_valid), 32'd1);
    instr_ready = 1'b1;
    tick();
    // J: one popped, second entry intact
    instr_ready = 1'b0; imem_req_ready = 1'b0; #1;
    chk("J_instr_pc", instr_pc, 32'hC);
    chk("J_instr", instr, mem(32'hC));
    chk("J_req_valid", 32'(imem_req_valid), 32'd1);
    chk("J_req_addr", imem_req_addr, 32'h10);
    tick();
    // K
    imem_req_ready = 1'b1; instr_ready = 1'b1; #1;
    chk("K_req_addr", imem_req_addr, 32'h10);
    tick();
    // L
    #1;
    chk("L_req_addr", imem_req_addr, 32'h14);
    chk("L_instr_valid", 32'(instr_valid), 32'd0);
    tick();
    // M: redirect with two outstanding
    redirect_valid = 1'b1; redirect_target = 32'h0000_0103; #1;
    chk("M_req_valid", 32'(imem_req_valid), 32'd0);
    tick();
    // N, O: two stale responses
    redirect_valid = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = mem(32'h10); #1;
    chk("N_req_valid", 32'(imem_req_valid), 32'd0);
    chk("N_instr_valid", 32'(instr_valid), 32'd0);
    tick();
    imem_rsp_data = mem(32'h14); #1;
    chk("O_req_valid", 32'(imem_req_valid), 32'd1);
    chk("O_req_addr", imem_req_addr, 32'h100);
    tick();
    // P: response for 0x100
    imem_rsp_data = mem(32'h100); imem_req_ready = 1'b0; #1;
    chk("P_instr_valid", 32'(instr_valid), 32'd0);
    chk("P_req_addr", imem_req_addr, 32'h104);
    tick();
    // Q
    imem_rsp_valid = 1'b0; imem_req_ready = 1'b1; instr_ready = 1'b0; #1;
    chk("Q_instr_valid", 32'(instr_valid), 32'd1);
    chk("Q_instr_pc", instr_pc, 32'h100);
    chk("Q_instr", instr, mem(32'h100));
    tick();
    // R: redirect coincident with response and pop
    redirect_valid = 1'b1; redirect_target = 32'h0000_0200;
    imem_rsp_valid = 1'b1; imem_rsp_data = mem(32'h104); instr_ready = 1'b1; #1;
    chk("R_req_valid", 32'(imem_req_valid), 32'd0);
    chk("R_instr_valid", 32'(instr_valid), 32'd1);
    tick();
    // S
    redirect_valid = 1'b0; imem_rsp_valid = 1'b0; #1;
    chk("S_instr_valid", 32'(instr_valid), 32'd0);
    chk("S_req_valid", 32'(imem_req_valid), 32'd1);
    chk("S_req_addr", imem_req_addr, 32'h200);
    tick();
    // T: nothing left to drop, so this response is kept
    imem_rsp_valid = 1'b1; imem_rsp_data = mem(32'h200); imem_req_ready = 1'b0; #1;
    chk("T_req_addr", imem_req_addr, 32'h204);
    chk("T_instr_valid", 32'(instr_valid), 32'd0);
    tick();
    // U: spurious response with nothing outstanding
    imem_rsp_data = 32'hDEAD_BEEF; instr_ready = 1'b0; #1;
    chk("U_instr_valid", 32'(instr_valid), 32'd1);
    chk("U_instr_pc", instr_pc, 32'h200);
    chk("U_instr", instr, mem(32'h200));
    tick();
    // V
    imem_rsp_valid = 1'b0; #1;
    chk("V_req_valid", 32'(imem_req_valid), 32'd1);
    chk("V_instr_pc", instr_pc, 32'h200);
    instr_ready = 1'b1;
    tick();
    // W: spurious response was not buffered; redirect near top of memory
    instr_ready = 1'b0; #1;
    chk("W_instr_valid", 32'(instr_valid), 32'd0);
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFE; #1;
    chk("W_req_valid", 32'(imem_req_valid), 32'd0);
    tick();
    // X, Y: address wrap
    redirect_valid = 1'b0; imem_req_ready = 1'b1; #1;
    chk("X_req_addr", imem_req_addr, 32'hFFFF_FFFC);
    tick();
    imem_req_ready = 1'b0; #1;
    chk("Y_req_valid", 32'(imem_req_valid), 32'd1);
    chk("Y_req_addr", imem_req_addr, 32'h0);
    tick();
    // Z
    imem_rsp_valid = 1'b1; imem_rsp_data = mem(32'hFFFF_FFFC);
    tick();
    // AA
    imem_rsp_valid = 1'b0; imem_req_ready = 1'b1; #1;
    chk("AA_req_addr", imem_req_addr, 32'h0);
    tick();
    // AB: one buffered, one outstanding, then reset mid-cycle
    imem_req_ready = 1'b0; #1;
    chk("AB_instr_valid", 32'(instr_valid), 32'd1);
    chk("AB_instr_pc", instr_pc, 32'hFFFF_FFFC);
    chk("AB_instr", instr, mem(32'hFFFF_FFFC));
    rst_n = 1'b0; #1;
    chk("AB_rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("AB_rst_req_valid", 32'(imem_req_valid), 32'd0);
    tick();
    // AC: release with the late response arriving
    rst_n = 1'b1; imem_rsp_valid = 1'b1; imem_rsp_data = mem(32'h0); #1;
    chk("AC_req_valid", 32'(imem_req_valid), 32'd1);
    chk("AC_req_addr", imem_req_addr, 32'h0);
    chk("AC_instr_valid", 32'(instr_valid), 32'd0);
    tick();
    // AD
    imem_rsp_valid = 1'b0; #1;
    chk("AD_instr_valid", 32'(instr_valid), 32'd0);
    chk("AD_req_valid", 32'(imem_req_valid), 32'd1);
    chk("AD_req_addr", imem_req_addr, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000: address of the first fetch after reset.
REQ-002 Parameter DEPTH, 2: instruction buffer entries, and also the maximum outstanding-plus-buffered instructions.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 imem_req_valid  out  1  fetch request valid.
REQ-006 imem_req_ready  in  1  instruction memory accepts the request.
REQ-007 imem_req_addr  out  32  word-aligned fetch address.
REQ-008 imem_rsp_valid  in  1  response data valid; in order, at least 1 cycle after acceptance.
REQ-009 imem_rsp_data  in  32  fetched instruction word.
REQ-010 redirect_valid  in  1  taken branch/jump (controller pc_src).
REQ-011 redirect_target  in  32  new PC; bits [1:0] ignored and treated as 00.
REQ-012 instr_valid  out  1  buffer head valid to decode.
REQ-013 instr_ready  in  1  decode consumes the head.
REQ-014 instr  out  32  head instruction word.
REQ-015 instr_pc  out  32  PC of the head instruction.
REQ-016 op / func3 / func7  out  7 / 3 / 7  instr[6:0] / instr[14:12] / instr[31:25], combinational slices.

Function
REQ-017 Three counters are kept: fetch_pc (next request address), outstanding (accepted requests with no response yet, 0..DEPTH) and count (buffer occupancy, 0..DEPTH).
REQ-018 Request rule: imem_req_valid = !redirect_valid & (outstanding + count < DEPTH); imem_req_addr = fetch_pc.
REQ-019 Request acceptance (req_valid & req_ready): fetch_pc += 4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0) and outstanding += 1.
REQ-020 Response handling: every imem_rsp_valid decrements outstanding.
REQ-021 A response is pushed to the buffer only if drop_count == 0; otherwise it is discarded and drop_count decrements.
REQ-022 Pushed entries carry {rsp_pc, data}; rsp_pc += 4 per pushed entry.
REQ-023 Buffer is FIFO: instr_valid = (count != 0); the head drives instr/instr_pc; the head pops on instr_valid & instr_ready; push and pop in the same cycle are allowed at any occupancy.
REQ-024 Overflow is impossible by REQ-018; the minimum latency from response to instr_valid is 1 cycle (no bypass).
REQ-025 Redirect (cycle with redirect_valid=1):
- buffer flushed (count <= 0), and no pop counts as consumed;
- fetch_pc <= target and rsp_pc <= target;
- no request is issued;
- drop_count <= outstanding - imem_rsp_valid;
- a response arriving in the redirect cycle is discarded.
REQ-026 Back-to-back redirects: the last one wins; drop_count is recomputed each time per REQ-025.
REQ-027 imem_rsp_valid while outstanding == 0 is a protocol error and is ignored (no state change).
REQ-028 Outputs are glitch-free functions of registers except imem_req_valid, which is combinational on redirect_valid.

Reset
REQ-029 rst_n low asynchronously sets: fetch_pc = rsp_pc = RESET_PC; outstanding = count = drop_count = 0; instr_valid = 0; imem_req_valid = 0 while in reset.
REQ-030 Reset mid-operation discards all in-flight and buffered instructions; responses to pre-reset requests arriving after release are ignored per REQ-027.
REQ-031 After release: first request at RESET_PC in the first cycle with rst_n high.

Verification
REQ-032 Reset, req_ready=1, 1-cycle memory, instr_ready=1 -> requests at 0,4,8,...; instr_valid first high 2 cycles after the first acceptance; instr_pc sequence 0,4,8 with matching data.
REQ-033 instr_ready=0 with DEPTH=2 -> exactly 2 requests issued, count=2, then imem_req_valid=0 until a pop; no entry lost or duplicated.
REQ-034 Redirect to 32'h0000_0103 with 2 outstanding -> both stale responses discarded; next request addr 32'h0000_0100; first delivered instr_pc = 32'h100.
REQ-035 Redirect in the same cycle as rsp_valid and instr_valid&ready -> response dropped, buffer empty next cycle, drop_count = outstanding-1.
REQ-036 fetch_pc = 32'hFFFF_FFFC -> next request addr 32'h0000_0000.
REQ-037 rst_n pulsed low mid-stream with 1 outstanding -> instr_valid=0 immediately; after release, the late response is ignored; first fetch at RESET_PC.
